// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access pipeline stage: access sizes,
// result-source selects and the bus handshake state machine states.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RS_ALU  = 2'b00;
   localparam logic [1:0] RS_LOAD = 2'b01;
   localparam logic [1:0] RS_PC4  = 2'b10;

   typedef enum logic {IDLE, WAIT} mem_state_t;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;

   // Unknown size codes fall back to a full word access.
   function automatic access_size_t size_of(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_of = SZ_BYTE;
         F3_H, F3_HU: size_of = SZ_HALF;
         F3_W:        size_of = SZ_WORD;
         default:     size_of = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it to 32 bits according to the load type.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   value = {24'd0, byte_sel};
         F3_H:    value = {{16{half_sel[15]}}, half_sel};
         F3_HU:   value = {16'd0, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues loads/stores on a ready-based bus, stalls the
// upstream pipeline while an access is outstanding, and registers writeback.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DR,
   input  logic [4:0]  DR_num,
   input  logic [31:0] WriteData,
   input  logic [31:0] PC_plus_4,
   input  logic [2:0]  Funct3,
   input  logic [1:0]  ResultSrc,
   input  logic        MemWrite,
   input  logic        RegWrite,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] ALUResData,
   output logic [31:0] DataReadData,
   output logic [31:0] WB_Result,
   output logic [4:0]  WB_RD_num,
   output logic        WB_RegWrite,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

   mem_state_t   state, state_next;
   access_size_t size;
   logic [7:0]   wait_cnt, wait_cnt_next;
   logic         is_store, is_load, is_mem, aligned, misaligned, abandon;
   logic [31:0]  load_value, wb_value;

   // A load that also asserts MemWrite is handled purely as a store.
   assign is_store   = MemWrite;
   assign is_load    = (ResultSrc == RS_LOAD) & ~MemWrite;
   assign is_mem     = is_load | is_store;
   assign size       = size_of(Funct3);
   assign misaligned = is_mem & ~aligned;

   always_comb begin
      aligned = 1'b1;
      case (size)
         SZ_HALF: aligned = ~DR[0];
         SZ_WORD: aligned = (DR[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   // Request/wait sequencing; a ready in the last tolerated cycle still wins.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      mem_req       = 1'b0;
      abandon       = 1'b0;
      case (state)
         IDLE: begin
            if (is_mem & aligned) begin
               mem_req = 1'b1;
               if (!mem_ready) begin
                  state_next    = WAIT;
                  wait_cnt_next = 8'd1;
               end
            end
         end
         WAIT: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               state_next    = IDLE;
               wait_cnt_next = 8'd0;
            end else if (wait_cnt == MAX_WAIT_CNT) begin
               abandon       = 1'b1;
               state_next    = IDLE;
               wait_cnt_next = 8'd0;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_next    = IDLE;
            wait_cnt_next = 8'd0;
         end
      endcase
      if (reset) begin
         mem_req = 1'b0;
      end
   end

   assign stall = mem_req & ~mem_ready & ~abandon;

   // Sub-word stores replicate the data across lanes; enables pick the lanes.
   always_comb begin
      mem_we    = is_store;
      mem_addr  = {DR[31:2], 2'b00};
      mem_wdata = WriteData;
      mem_be    = 4'b1111;
      case (size)
         SZ_BYTE: begin
            mem_wdata = {4{WriteData[7:0]}};
            mem_be    = 4'b0001 << DR[1:0];
         end
         SZ_HALF: begin
            mem_wdata = {2{WriteData[15:0]}};
            mem_be    = 4'b0011 << DR[1:0];
         end
         default: begin
            mem_wdata = WriteData;
            mem_be    = 4'b1111;
         end
      endcase
      if (!is_store) begin
         mem_be = 4'b1111;
      end
   end

   mem_load_align u_load_align (
      .rdata  (mem_rdata),
      .addr   (DR[1:0]),
      .funct3 (Funct3),
      .value  (load_value)
   );

   always_comb begin
      case (ResultSrc)
         RS_LOAD: wb_value = is_load ? load_value : DR;
         RS_PC4:  wb_value = PC_plus_4;
         RS_ALU:  wb_value = DR;
         default: wb_value = DR;
      endcase
   end

   // Stalled cycles retire a bubble; errors retire without a register write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         WB_Result    <= 32'd0;
         WB_RD_num    <= 5'd0;
         WB_RegWrite  <= 1'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state        <= state_next;
         wait_cnt     <= wait_cnt_next;
         misalign_err <= (state == IDLE) & misaligned;
         bus_err      <= abandon;
         if (stall) begin
            WB_RegWrite <= 1'b0;
         end else begin
            WB_Result   <= wb_value;
            WB_RD_num   <= DR_num;
            WB_RegWrite <= RegWrite & ~is_store & ~abandon
                           & ~((state == IDLE) & misaligned);
         end
      end
   end

   assign ALUResData   = DR;
   assign DataReadData = WB_Result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a per-instruction model derives bus,
// stall and writeback expectations, checked every cycle plus literal pins.
module tb_mem_access_stage;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] DR, WriteData, PC_plus_4, mem_rdata;
   logic [4:0]  DR_num;
   logic [2:0]  Funct3;
   logic [1:0]  ResultSrc;
   logic        MemWrite, RegWrite, mem_ready;
   logic        mem_req, mem_we, stall, WB_RegWrite, misalign_err, bus_err;
   logic [31:0] mem_addr, mem_wdata, ALUResData, DataReadData, WB_Result;
   logic [3:0]  mem_be;
   logic [4:0]  WB_RD_num;

   int total = 0;
   int bad = 0;
   logic check_en = 1'b0;

   // model expectations
   logic        m_req, m_stall, m_we, m_wb_we, m_mis, m_bus, m_res_known;
   logic [31:0] m_addr, m_wdata, m_alu, m_wb_result;
   logic [3:0]  m_be;
   logic [4:0]  m_wb_rd;

   // observations used by the literal pins
   int          stall_seen, req_seen;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;

   always #5 clk = ~clk;

   mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .DR(DR), .DR_num(DR_num), .WriteData(WriteData),
      .PC_plus_4(PC_plus_4), .Funct3(Funct3), .ResultSrc(ResultSrc),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
      .ALUResData(ALUResData), .DataReadData(DataReadData), .WB_Result(WB_Result),
      .WB_RD_num(WB_RD_num), .WB_RegWrite(WB_RegWrite),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
      end
   endtask

   function automatic logic [31:0] loadValue(input logic [31:0] rdata,
                                             input logic [1:0] a, input logic [2:0] f3);
      logic [31:0] sh;
      sh = rdata >> (8 * a);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return rdata;
      endcase
   endfunction

   task automatic modelReset();
      m_wb_result = 32'd0;
      m_wb_rd     = 5'd0;
      m_wb_we     = 1'b0;
      m_mis       = 1'b0;
      m_bus       = 1'b0;
      m_res_known = 1'b1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("stall", stall, m_stall);
         checkOutput("mem_req", mem_req, m_req);
         if (m_req) begin
            checkOutput("mem_we", mem_we, m_we);
            checkOutput("mem_addr", mem_addr, m_addr);
            checkOutput("mem_be", mem_be, m_be);
            if (m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
         end
         checkOutput("ALUResData", ALUResData, m_alu);
         checkOutput("WB_RegWrite", WB_RegWrite, m_wb_we);
         checkOutput("WB_RD_num", WB_RD_num, m_wb_rd);
         checkOutput("misalign_err", misalign_err, m_mis);
         checkOutput("bus_err", bus_err, m_bus);
         if (m_res_known) begin
            checkOutput("WB_Result", WB_Result, m_wb_result);
            checkOutput("DataReadData", DataReadData, m_wb_result);
         end
         if (stall === 1'b1) stall_seen++;
         if (mem_req === 1'b1) begin
            req_seen++;
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
         end
      end
   end

   // One instruction held at the stage inputs until it retires. lat = cycles
   // before the bus answers; rst_at = cycle at which reset is asserted (-1 none).
   task automatic applyStimulus(input logic [31:0] dr, input logic [4:0] rd,
                                input logic [31:0] wd, input logic [31:0] pc4,
                                input logic [2:0] f3, input logic [1:0] rs,
                                input logic mw, input logic rw,
                                input logic [31:0] rdata, input int lat, input int rst_at);
      logic ld, mem, ok, mis, tmo;
      int sz, n;
      logic [31:0] res;
      ld  = (rs == 2'b01) && !mw;
      mem = ld || mw;
      sz  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
      ok  = (dr % sz) == 0;
      mis = mem && !ok;
      tmo = mem && ok && (lat > MAX_WAIT);
      n   = (mem && ok) ? (((lat > MAX_WAIT) ? MAX_WAIT : lat) + 1) : 1;
      res = ld ? loadValue(rdata, dr[1:0], f3) : (rs == 2'b10) ? pc4 : dr;

      stall_seen = 0;
      req_seen   = 0;
      DR = dr; DR_num = rd; WriteData = wd; PC_plus_4 = pc4;
      Funct3 = f3; ResultSrc = rs; MemWrite = mw; RegWrite = rw;
      m_alu   = dr;
      m_we    = mw;
      m_addr  = dr & ~32'h3;
      m_be    = !mw ? 4'hF : (sz == 1) ? (4'b0001 << dr[1:0])
                           : (sz == 2) ? (4'b0011 << dr[1:0]) : 4'hF;
      m_wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;

      for (int c = 0; c < n; c++) begin
         mem_ready = (mem && ok) ? (c == lat) : (lat == 0);
         mem_rdata = (c == lat) ? rdata : ~rdata;
         if (c == rst_at) begin
            reset   = 1'b1;
            m_req   = 1'b0;
            m_stall = 1'b0;
         end else begin
            m_req   = mem && ok;
            m_stall = (c < n - 1);
         end
         @(posedge clk);
         #1;
         if (c == rst_at) begin
            reset = 1'b0;
            modelReset();
            return;
         end
         if (c == n - 1) begin
            m_wb_rd = rd;
            m_wb_we = rw && !mw && !mis && !tmo;
            m_mis   = mis;
            m_bus   = tmo;
            if (!mis && !tmo && !(mw && rs == 2'b01)) begin
               m_wb_result = res;
               m_res_known = 1'b1;
            end else begin
               m_res_known = 1'b0;
            end
         end else begin
            m_wb_we = 1'b0;
            m_mis   = 1'b0;
            m_bus   = 1'b0;
         end
      end
   endtask

   task automatic applyNop();
      applyStimulus(32'd0, 5'd0, 32'd0, 32'd0, 3'b000, 2'b00, 1'b0, 1'b0, 32'd0, 1, -1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] simulation did not terminate");
   end

   initial begin
      reset = 1'b1;
      DR = 0; DR_num = 0; WriteData = 0; PC_plus_4 = 0; Funct3 = 0; ResultSrc = 0;
      MemWrite = 0; RegWrite = 0; mem_ready = 0; mem_rdata = 0;
      m_req = 0; m_stall = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0; m_alu = 0;
      modelReset();
      @(posedge clk); #1;
      check_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("reset WB_Result", WB_Result, 32'h0);
      checkOutput("reset WB_RegWrite", WB_RegWrite, 32'h0);
      checkOutput("reset bus_err", bus_err, 32'h0);

      // ALU op; mem_ready pulsed while no request must be ignored
      applyStimulus(32'h1234, 5'd5, 32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b1, 32'h0, 0, -1);
      checkOutput("alu WB_Result", WB_Result, 32'h1234);
      checkOutput("alu WB_RD_num", WB_RD_num, 32'd5);
      checkOutput("alu WB_RegWrite", WB_RegWrite, 32'd1);
      checkOutput("alu stall cycles", stall_seen, 32'd0);

      // LB zero wait
      applyStimulus(32'h103, 5'd6, 32'h0, 32'h0, 3'b000, 2'b01, 1'b0, 1'b1, 32'h80FF0000, 0, -1);
      checkOutput("lb mem_addr", last_addr, 32'h100);
      checkOutput("lb WB_Result", WB_Result, 32'hFFFFFF80);
      checkOutput("lb stall cycles", stall_seen, 32'd0);

      // SH with three wait cycles
      applyStimulus(32'h202, 5'd7, 32'hABCD1234, 32'h0, 3'b001, 2'b00, 1'b1, 1'b1, 32'h0, 3, -1);
      checkOutput("sh stall cycles", stall_seen, 32'd3);
      checkOutput("sh mem_be", last_be, 32'b1100);
      checkOutput("sh mem_wdata", last_wdata, 32'h12341234);
      checkOutput("sh WB_RegWrite", WB_RegWrite, 32'd0);

      // misaligned LW
      applyStimulus(32'h301, 5'd8, 32'h0, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 32'h0, 0, -1);
      checkOutput("misalign mem_req cycles", req_seen, 32'd0);
      checkOutput("misalign_err pulse", misalign_err, 32'd1);
      checkOutput("misalign WB_RegWrite", WB_RegWrite, 32'd0);

      // LW never answered
      applyStimulus(32'h400, 5'd9, 32'h0, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 32'h0, 1000, -1);
      checkOutput("timeout stall cycles", stall_seen, 32'd4);
      checkOutput("timeout bus_err", bus_err, 32'd1);
      checkOutput("timeout WB_RegWrite", WB_RegWrite, 32'd0);

      // LHU with reset in the second WAIT cycle
      applyStimulus(32'h502, 5'd10, 32'h0, 32'h0, 3'b101, 2'b01, 1'b0, 1'b1, 32'h80010000, 100, 2);
      checkOutput("rstwait stall cycles", stall_seen, 32'd2);
      checkOutput("rstwait WB_Result", WB_Result, 32'h0);
      checkOutput("rstwait WB_RD_num", WB_RD_num, 32'h0);
      checkOutput("rstwait bus_err", bus_err, 32'h0);

      // LHU answered exactly at the wait limit
      applyStimulus(32'h502, 5'd11, 32'h0, 32'h0, 3'b101, 2'b01, 1'b0, 1'b1, 32'h80010000, 4, -1);
      checkOutput("lhu limit WB_Result", WB_Result, 32'h00008001);
      checkOutput("lhu limit bus_err", bus_err, 32'h0);

      applyStimulus(32'h0, 5'd12, 32'h0, 32'h0, 3'b001, 2'b01, 1'b0, 1'b1, 32'h00008001, 1, -1);
      checkOutput("lh WB_Result", WB_Result, 32'hFFFF8001);
      applyStimulus(32'h1, 5'd13, 32'h0, 32'h0, 3'b100, 2'b01, 1'b0, 1'b1, 32'h00009A00, 2, -1);
      checkOutput("lbu WB_Result", WB_Result, 32'h0000009A);
      applyStimulus(32'h13, 5'd14, 32'h55, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'h0, 0, -1);
      checkOutput("sb mem_be", last_be, 32'b1000);
      applyStimulus(32'h20, 5'd15, 32'hCAFEF00D, 32'h0, 3'b010, 2'b00, 1'b1, 1'b1, 32'h0, 1, -1);
      checkOutput("sw mem_wdata", last_wdata, 32'hCAFEF00D);
      applyStimulus(32'h99, 5'd0, 32'h0, 32'h404, 3'b000, 2'b10, 1'b0, 1'b1, 32'h0, 1, -1);
      checkOutput("pc4 WB_Result", WB_Result, 32'h404);
      checkOutput("pc4 x0 WB_RegWrite", WB_RegWrite, 32'd1);
      applyStimulus(32'h77, 5'd16, 32'h0, 32'h888, 3'b000, 2'b11, 1'b0, 1'b1, 32'h0, 1, -1);
      checkOutput("rs11 WB_Result", WB_Result, 32'h77);
      // load and store together behaves as a store
      applyStimulus(32'h30, 5'd17, 32'h01020304, 32'h0, 3'b010, 2'b01, 1'b1, 1'b1, 32'h0, 0, -1);
      checkOutput("ldst WB_RegWrite", WB_RegWrite, 32'd0);
      applyStimulus(32'h1, 5'd18, 32'h0, 32'h0, 3'b001, 2'b01, 1'b0, 1'b1, 32'h0, 0, -1);
      checkOutput("lh misalign_err", misalign_err, 32'd1);
      applyStimulus(32'h40, 5'd19, 32'h0, 32'h0, 3'b111, 2'b01, 1'b0, 1'b1, 32'h11223344, 0, -1);
      checkOutput("f3 111 as LW", WB_Result, 32'h11223344);
      applyNop();
      applyNop();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory stage sitting directly downstream of the execute stage: consumes the registered ALU result, store data, destination number and control bits, performs loads/stores over a wait-state-tolerant ready-based data bus, and registers the writeback result. Generates the stall that freezes all upstream pipeline registers while a bus access is outstanding. Supplies the two forwarding values selected by the execute-stage operand muxes: select 1 = DataReadData, select 2 = ALUResData.

## Interface
Parameters:
- MAX_WAIT, 255, wait cycles tolerated in WAIT before the access is abandoned; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- DR  in  32  ALU result; the byte address for memory ops
- DR_num  in  5  destination register
- WriteData  in  32  store data (unaligned, bits [7:0]/[15:0]/[31:0] significant)
- PC_plus_4  in  32  link value
- Funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
- ResultSrc  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as 00)
- MemWrite  in  1  store
- RegWrite  in  1  writeback enable
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {DR[31:2],2'b00}
- mem_wdata  out  32  store data replicated to lanes
- mem_be  out  4  byte enables
- mem_ready  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word
- stall  out  1  freeze upstream registers
- ALUResData  out  32  forwarding value = DR (combinational)
- DataReadData  out  32  forwarding value = WB_Result
- WB_Result  out  32  registered writeback value
- WB_RD_num  out  5  registered destination
- WB_RegWrite  out  1  registered writeback enable
- misalign_err  out  1  one-cycle pulse, misaligned access
- bus_err  out  1  one-cycle pulse, timeout

## Operation
- is_load = ResultSrc==01; is_mem = is_load | MemWrite. Both set: treated as store, RegWrite forced 0.
- Alignment: half needs DR[0]==0; word needs DR[1:0]==00. Misaligned op: no bus request, misalign_err pulses, instruction retires with WB_RegWrite=0, no stall.
- States: IDLE, WAIT.
- IDLE, aligned is_mem: mem_req=1 combinationally. mem_ready=1 that cycle -> retire, stay IDLE. Else -> WAIT, counter=1.
- WAIT: mem_req=1, bus fields held (inputs frozen by stall). mem_ready -> retire, IDLE. counter==MAX_WAIT without ready -> abandon: bus_err pulse, retire with WB_RegWrite=0, IDLE. Else counter++.
- mem_req gated low while reset=1.
- stall = mem_req & ~mem_ready & ~abandon.
- Store lanes: SB wdata={4{WriteData[7:0]}}, be=0001<<DR[1:0]; SH wdata={2{WriteData[15:0]}}, be=0011<<DR[1:0]; SW wdata=WriteData, be=1111. Loads: be=1111, we=0.
- Load extraction: byte lane DR[1:0], half lane DR[1]; LB/LH sign-extend, LBU/LHU zero-extend; other Funct3 values on load treated as LW.
- Retire: WB_Result = loaded value / PC_plus_4 / DR per ResultSrc; WB_RD_num=DR_num; WB_RegWrite=RegWrite & ~err & ~store. DR_num==0 still written; x0 masking is register file's job.
- Stalled cycle: WB registers load bubble (WB_RegWrite=0, WB_Result, WB_RD_num held).

## Timing
- Reset: state IDLE, counter 0, WB_Result 0, WB_RD_num 0, WB_RegWrite 0, misalign_err 0, bus_err 0; mem_req 0 during reset cycle. Reset mid-WAIT abandons the access silently (no bus_err).
- Non-memory op: WB registers updated at the next edge (1-cycle latency).
- Memory op ready after k wait cycles (k=0 same cycle): stall high k cycles, WB updated at the edge where mem_ready is sampled high.
- Timeout: stall high MAX_WAIT cycles; bus_err and bubble-retire at edge MAX_WAIT+1 after request start.
- mem_ready while mem_req=0: ignored.
- Error pulses registered, coincident with the retiring WB update.

## Structure
- Package mem_pkg: Funct3 localparams, ResultSrc encodings, state enum {IDLE, WAIT}.
- Sub-module mem_load_align: combinational lane extract + sign/zero extension (rdata, addr[1:0], Funct3 -> 32-bit value).
- Top: FSM, wait counter, store lane logic, WB registers.

## Test plan
- ALU op DR=0x1234, DR_num=5, RegWrite=1 -> next edge WB_Result=0x1234, WB_RD_num=5, WB_RegWrite=1, stall never high.
- LB DR=0x103, mem_rdata=0x80FF0000, mem_ready same cycle -> mem_addr=0x100, WB_Result=0xFFFFFF80, no stall.
- SH DR=0x202, WriteData=0xABCD1234, ready after 3 cycles -> stall 3 cycles, mem_be=1100, mem_wdata=0x12341234, WB_RegWrite=0.
- LW DR=0x301 -> no mem_req, misalign_err one pulse, WB_RegWrite=0.
- MAX_WAIT=4, LW never ready -> stall 4 cycles, then mem_req low, bus_err pulse, WB_RegWrite=0.
- LHU ready delayed, reset asserted in 2nd WAIT cycle -> next cycle IDLE, all outputs reset values, no bus_err.
